bsg_link_ddr_downstream_ctrl: RTL and testbench
===============================================

Name: bsg_link_ddr_downstream_ctrl

Overview:
Core-clock bring-up and recovery sequencer for a multi-channel DDR link receiver.
- Drives the receiver's core link reset.
- Drives per-channel IO link reset requests, which external synchronizers carry into each io_clk domain.
- Waits for every remote IO clock to be alive, then releases resets in the required order (IO first, then core).
- Detects clock loss, retries on timeout, and reports link-up or failure to the core.

Parameters:
- num_channels_p, 1, number of physical IO channels controlled.
- io_reset_cycles_p, 32, core cycles IO resets stay asserted after all clocks are alive.
- core_reset_cycles_p, 16, core cycles core reset stays asserted after IO reset release.
- timeout_cycles_p, 4096, core cycles to wait for all clocks alive before one attempt counts as failed.
- max_retries_p, 3, failed attempts allowed before entering FAIL.

Ports:
- clk_i  in  1  core clock.
- reset_i  in  1  synchronous, active-high reset.
- start_i  in  1  begin bring-up (sampled in IDLE and FAIL only).
- force_reset_i  in  1  request a full re-sequence from UP or any reset state.
- io_clk_alive_i  in  num_channels_p  per-channel "remote clock toggling" flag, already synchronized to clk_i.
- core_link_reset_o  out  1  reset to the receiver core side.
- io_link_reset_req_o  out  num_channels_p  per-channel IO reset request (level).
- link_up_o  out  1  link operational.
- fail_o  out  1  retries exhausted.
- state_o  out  3  current state encoding, for debug.

Behaviour:
- Interface: one clock, clk_i; reset_i is synchronous and active-high.
- Reset: state=IDLE; core_link_reset_o=1; io_link_reset_req_o all 1; link_up_o=0; fail_o=0; cycle counter=0; retry count=0.
- Outputs are registered from state. Both resets are asserted in every state except UP; the exception is CORE_RST, where IO requests are 0.
- IDLE: start_i=1 -> WAIT_CLK with counter cleared and retry count cleared.
- WAIT_CLK: counter increments each cycle.
  - All io_clk_alive_i=1 -> IO_RST, counter cleared.
  - Otherwise, at counter==timeout_cycles_p-1: if retries==max_retries_p -> FAIL; else retries+1, stay in WAIT_CLK, counter cleared.
- IO_RST: hold both resets for io_reset_cycles_p cycles, then -> CORE_RST.
- CORE_RST: io_link_reset_req_o=0, core_link_reset_o=1 for core_reset_cycles_p cycles, then -> UP.
- UP: all resets 0; link_up_o=1; retry count cleared on entry.
- Clock loss:
  - Any io_clk_alive_i=0 in IO_RST or CORE_RST -> WAIT_CLK; retries+1, or FAIL if already at max.
  - Any io_clk_alive_i=0 in UP -> WAIT_CLK; resets reassert on the next cycle; link_up_o falls on the same edge.
- force_reset_i=1 in UP, IO_RST or CORE_RST -> WAIT_CLK; retry count unchanged. It has priority over clock-loss and counter-expiry transitions in the same cycle.
- FAIL: fail_o=1, resets asserted. start_i -> WAIT_CLK, clearing retries and fail_o.
- Ignored inputs: start_i outside IDLE/FAIL; force_reset_i in IDLE/FAIL.
- Counters: width $clog2 of the largest cycle parameter + 1; no wrap, since every expiry causes a transition.
- Elaboration-time check: all cycle parameters must be ≥1.
- reset_i mid-sequence returns to the reset values above on the next edge.

Optional Feature:
- Macro: BSG_LINK_DDR_CTRL_STATS_EN.
- When defined, adds two outputs:
  - retry_total_o[15:0]: increments on every retry.
  - drop_total_o[15:0]: increments on every UP->WAIT_CLK transition caused by clock loss.
  - Both saturate at 16'hFFFF and are cleared only by reset_i.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package bsg_link_ddr_ctrl_pkg holds:
  - the state enum, 3 bits: IDLE=0, WAIT_CLK=1, IO_RST=2, CORE_RST=3, UP=4, FAIL=5;
  - stats counter width constant = 16.
- One natural sub-module: bsg_link_ddr_ctrl_timer, a loadable down-counter with expiry flag, shared by the three timed states.

Test Plan:
- Normal bring-up: reset, start_i pulse, all alive at cycle 5 -> IO requests fall after 32 cycles in IO_RST, core reset falls 16 cycles later, link_up_o=1.
- Timeout/retry: alive held 0, timeout_cycles_p=16, max_retries_p=3 -> fail_o=1 after 64 cycles; start_i with alive=1 -> UP reached, fail_o cleared.
- Clock loss in UP: drop io_clk_alive_i[1] for 1 cycle (num_channels_p=2) -> link_up_o=0 and resets reasserted next cycle; re-sequence to UP; drop_total_o=1 if stats enabled.
- Priority: force_reset_i and alive drop on the same cycle in UP -> WAIT_CLK, retry count unchanged, drop_total_o unchanged.
- Mid-sequence reset_i: assert during CORE_RST -> IO requests back to 1 and state_o=0 next edge.
- Start ignored: start_i held in UP -> no state change; start_i during WAIT_CLK -> counter not cleared.

Source files
------------

// File: rtl/bsg_link_ddr_ctrl_pkg.sv
// Shared types and constants for the DDR link downstream bring-up sequencer.
// The optional statistics counters in the top are enabled by BSG_LINK_DDR_CTRL_STATS_EN.
package bsg_link_ddr_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_CLK = 3'd1,
    IO_RST   = 3'd2,
    CORE_RST = 3'd3,
    UP       = 3'd4,
    FAIL     = 3'd5
  } state_e;

  localparam int stats_width_gp = 16;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bsg_link_ddr_ctrl_timer.sv
// Loadable down-counter with an expiry flag, shared by the timed sequencer states.
// Holds at zero once expired so it never wraps.
module bsg_link_ddr_ctrl_timer #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic [width_p-1:0] load_val_i,
  output logic               expired_o
);

  logic [width_p-1:0] count_r;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i)
      count_r <= '0;
    else if (load_i)
      count_r <= load_val_i;
    else if (count_r != '0)
      count_r <= count_r - 1'b1;
  end

  assign expired_o = (count_r == '0);

endmodule

// File: rtl/bsg_link_ddr_downstream_ctrl.sv
// Core-clock bring-up and recovery sequencer for a multi-channel DDR link receiver.
// Define BSG_LINK_DDR_CTRL_STATS_EN to add saturating retry/drop counters.
module bsg_link_ddr_downstream_ctrl
  import bsg_link_ddr_ctrl_pkg::*;
#(
  parameter int num_channels_p      = 1,
  parameter int io_reset_cycles_p   = 32,
  parameter int core_reset_cycles_p = 16,
  parameter int timeout_cycles_p    = 4096,
  parameter int max_retries_p       = 3
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      start_i,
  input  logic                      force_reset_i,
  input  logic [num_channels_p-1:0] io_clk_alive_i,
  output logic                      core_link_reset_o,
  output logic [num_channels_p-1:0] io_link_reset_req_o,
  output logic                      link_up_o,
  output logic                      fail_o,
  output logic [2:0]                state_o
`ifdef BSG_LINK_DDR_CTRL_STATS_EN
  ,
  output logic [stats_width_gp-1:0] retry_total_o,
  output logic [stats_width_gp-1:0] drop_total_o
`endif
);

  localparam int ctr_width_lp =
    $clog2(max3(io_reset_cycles_p, core_reset_cycles_p, timeout_cycles_p)) + 1;
  localparam int retry_width_lp = (max_retries_p < 1) ? 1 : $clog2(max_retries_p + 1);

  localparam logic [ctr_width_lp-1:0] timeout_val_lp = ctr_width_lp'(timeout_cycles_p - 1);
  localparam logic [ctr_width_lp-1:0] io_val_lp      = ctr_width_lp'(io_reset_cycles_p - 1);
  localparam logic [ctr_width_lp-1:0] core_val_lp    = ctr_width_lp'(core_reset_cycles_p - 1);
  localparam logic [retry_width_lp-1:0] retry_max_lp = retry_width_lp'(max_retries_p);

  if (io_reset_cycles_p < 1 || core_reset_cycles_p < 1 || timeout_cycles_p < 1) begin : g_bad_cycles
    $error("bsg_link_ddr_downstream_ctrl: all cycle parameters must be >= 1");
  end

  state_e                    state_r, state_n;
  logic [retry_width_lp-1:0] retry_r, retry_n;
  logic                      tmr_load, tmr_expired;
  logic [ctr_width_lp-1:0]   tmr_val;
  logic                      all_alive, retry_at_max;

  assign all_alive    = &io_clk_alive_i;
  assign retry_at_max = (retry_r == retry_max_lp);
  assign state_o      = state_r;

  bsg_link_ddr_ctrl_timer #(.width_p(ctr_width_lp)) timer (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expired_o  (tmr_expired)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_n  = state_r;
    retry_n  = retry_r;
    tmr_load = 1'b0;
    unique case (state_r)
      IDLE, FAIL: if (start_i) begin
        state_n = WAIT_CLK;
        retry_n = '0;
      end
      WAIT_CLK: begin
        if (all_alive)
          state_n = IO_RST;
        else if (tmr_expired) begin
          if (retry_at_max)
            state_n = FAIL;
          else begin
            retry_n  = retry_r + 1'b1;
            tmr_load = 1'b1;
          end
        end
      end
      IO_RST, CORE_RST: begin
        if (force_reset_i)
          state_n = WAIT_CLK;
        else if (!all_alive) begin
          state_n = retry_at_max ? FAIL : WAIT_CLK;
          if (!retry_at_max) retry_n = retry_r + 1'b1;
        end else if (tmr_expired) begin
          state_n = (state_r == IO_RST) ? CORE_RST : UP;
          if (state_r == CORE_RST) retry_n = '0;
        end
      end
      UP: if (force_reset_i || !all_alive) state_n = WAIT_CLK;
      default: state_n = IDLE;
    endcase

    // Any state change restarts the timer with the budget of the state being entered.
    if (state_n != state_r) tmr_load = 1'b1;
    case (state_n)
      WAIT_CLK: tmr_val = timeout_val_lp;
      IO_RST:   tmr_val = io_val_lp;
      CORE_RST: tmr_val = core_val_lp;
      default:  tmr_val = '0;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_r.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r             <= IDLE;
      retry_r             <= '0;
      core_link_reset_o   <= 1'b1;
      io_link_reset_req_o <= '1;
      link_up_o           <= 1'b0;
      fail_o              <= 1'b0;
    end else begin
      state_r             <= state_n;
      retry_r             <= retry_n;
      core_link_reset_o   <= (state_n != UP);
      io_link_reset_req_o <= (state_n == CORE_RST || state_n == UP) ? '0 : '1;
      link_up_o           <= (state_n == UP);
      fail_o              <= (state_n == FAIL);
    end
  end

`ifdef BSG_LINK_DDR_CTRL_STATS_EN
  logic retry_evt, drop_evt;

  // Retry count only ever grows by one on a retry; every other change is a clear.
  assign retry_evt = (retry_n > retry_r);
  assign drop_evt  = (state_r == UP) && !force_reset_i && !all_alive;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      retry_total_o <= '0;
      drop_total_o  <= '0;
    end else begin
      if (retry_evt && retry_total_o != '1) retry_total_o <= retry_total_o + 1'b1;
      if (drop_evt && drop_total_o != '1)   drop_total_o  <= drop_total_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bsg_link_ddr_downstream_ctrl.sv
// Scoreboard bench: a cycle-level behavioural model queues expected outputs, a monitor compares.
// Stats checks are active when BSG_LINK_DDR_CTRL_STATS_EN is defined.
module tb_bsg_link_ddr_downstream_ctrl;

  localparam int N     = 2;
  localparam int IOC   = 32;
  localparam int COREC = 16;
  localparam int TOUT  = 16;
  localparam int MAXR  = 3;

  localparam int P_IDLE = 0, P_WAIT = 1, P_IO = 2, P_CORE = 3, P_UP = 4, P_FAIL = 5;

  logic         clk = 1'b0;
  logic         reset_i = 1'b1;
  logic         start_i = 1'b0;
  logic         force_reset_i = 1'b0;
  logic [N-1:0] io_clk_alive_i = '0;
  logic         core_link_reset_o;
  logic [N-1:0] io_link_reset_req_o;
  logic         link_up_o;
  logic         fail_o;
  logic [2:0]   state_o;
`ifdef BSG_LINK_DDR_CTRL_STATS_EN
  logic [15:0]  retry_total_o;
  logic [15:0]  drop_total_o;
`endif

  bsg_link_ddr_downstream_ctrl #(
    .num_channels_p      (N),
    .io_reset_cycles_p   (IOC),
    .core_reset_cycles_p (COREC),
    .timeout_cycles_p    (TOUT),
    .max_retries_p       (MAXR)
  ) dut (
    .clk_i               (clk),
    .reset_i             (reset_i),
    .start_i             (start_i),
    .force_reset_i       (force_reset_i),
    .io_clk_alive_i      (io_clk_alive_i),
    .core_link_reset_o   (core_link_reset_o),
    .io_link_reset_req_o (io_link_reset_req_o),
    .link_up_o           (link_up_o),
    .fail_o              (fail_o),
    .state_o             (state_o)
`ifdef BSG_LINK_DDR_CTRL_STATS_EN
    ,
    .retry_total_o       (retry_total_o),
    .drop_total_o        (drop_total_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  vec;
    logic [15:0] rtot;
    logic [15:0] dtot;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase + elapsed cycles in the current phase/attempt.
  int m_phase = P_IDLE, m_elapsed = 0, m_retries = 0, m_rtot = 0, m_dtot = 0;

  function automatic void m_enter(input int p);
    m_phase   = p;
    m_elapsed = 0;
  endfunction

  function automatic void m_lose();
    if (m_retries == MAXR) m_enter(P_FAIL);
    else begin
      m_retries++;
      m_rtot++;
      m_enter(P_WAIT);
    end
  endfunction

  function automatic void model_step(input logic s, input logic f, input logic [N-1:0] a, input logic r);
    bit all;
    all = (a == {N{1'b1}});
    if (r) begin
      m_enter(P_IDLE);
      m_retries = 0;
      m_rtot = 0;
      m_dtot = 0;
      return;
    end
    case (m_phase)
      P_IDLE, P_FAIL: if (s) begin m_retries = 0; m_enter(P_WAIT); end
      P_WAIT: begin
        if (all) m_enter(P_IO);
        else if (m_elapsed == TOUT - 1) begin
          if (m_retries == MAXR) m_enter(P_FAIL);
          else begin m_retries++; m_rtot++; m_elapsed = 0; end
        end else m_elapsed++;
      end
      P_IO, P_CORE: begin
        if (f) m_enter(P_WAIT);
        else if (!all) m_lose();
        else if (m_elapsed == ((m_phase == P_IO) ? IOC : COREC) - 1) begin
          if (m_phase == P_CORE) m_retries = 0;
          m_enter(m_phase + 1);
        end else m_elapsed++;
      end
      P_UP: begin
        if (f) m_enter(P_WAIT);
        else if (!all) begin m_dtot++; m_enter(P_WAIT); end
      end
      default: m_enter(P_IDLE);
    endcase
  endfunction

  function automatic exp_t model_expect();
    exp_t e;
    e.vec[7:5] = 3'(m_phase);
    e.vec[4]   = (m_phase != P_UP);
    e.vec[3:2] = (m_phase == P_CORE || m_phase == P_UP) ? 2'b00 : 2'b11;
    e.vec[1]   = (m_phase == P_UP);
    e.vec[0]   = (m_phase == P_FAIL);
    e.rtot     = 16'(m_rtot);
    e.dtot     = 16'(m_dtot);
    return e;
  endfunction

  task automatic cycle(input logic s, input logic f, input logic [N-1:0] a, input logic r);
    start_i        = s;
    force_reset_i  = f;
    io_clk_alive_i = a;
    reset_i        = r;
    @(posedge clk);
    model_step(s, f, a, r);
    exp_q.push_back(model_expect());
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("outputs{state,core,io,up,fail}",
            {24'b0, state_o, core_link_reset_o, io_link_reset_req_o, link_up_o, fail_o},
            {24'b0, mon_e.vec});
`ifdef BSG_LINK_DDR_CTRL_STATS_EN
      check("retry_total", {16'b0, retry_total_o}, {16'b0, mon_e.rtot});
      check("drop_total", {16'b0, drop_total_o}, {16'b0, mon_e.dtot});
`endif
    end
  end

  initial begin
    int n_io, n_up;
    logic [N-1:0] seg_a;
    int seg_len;

    repeat (3) cycle(0, 0, '0, 1);
    check("reset_state", {24'b0, state_o, core_link_reset_o, io_link_reset_req_o, link_up_o, fail_o},
          32'b000_1_11_0_0);

    // Normal bring-up: clocks come alive a few cycles after start.
    cycle(1, 0, '0, 0);
    repeat (4) cycle(0, 0, '0, 0);
    n_io = 0;
    n_up = 0;
    for (int i = 1; i <= 200; i++) begin
      cycle(0, 0, '1, 0);
      if (n_io == 0 && io_link_reset_req_o == '0) n_io = i;
      if (link_up_o) begin n_up = i; break; end
    end
    check("io_req_release_latency", n_io, 33);
    check("link_up_latency", n_up, 49);

    repeat (5) cycle(1, 0, '1, 0);
    check("start_ignored_in_up", {31'b0, link_up_o}, 1);

    // Single-cycle loss of channel 1 while up.
    cycle(0, 0, 2'b01, 0);
    check("drop_link_up", {31'b0, link_up_o}, 0);
    check("drop_core_reset", {31'b0, core_link_reset_o}, 1);
    repeat (60) cycle(0, 0, '1, 0);
    check("resequenced_up", {31'b0, link_up_o}, 1);

    // Force and clock loss together: force wins, no drop counted.
    cycle(0, 1, 2'b01, 0);
    check("force_priority_state", {29'b0, state_o}, 1);
    repeat (60) cycle(0, 0, '1, 0);

    // Timeout path to FAIL, then recovery via start.
    cycle(0, 1, '0, 0);
    repeat (70) cycle(0, 0, '0, 0);
    check("timeout_fail", {31'b0, fail_o}, 1);
    cycle(1, 0, '1, 0);
    repeat (60) cycle(0, 0, '1, 0);
    check("recover_fail_cleared", {30'b0, link_up_o, fail_o}, 32'b10);

    // Start during WAIT_CLK must not restart the timeout window.
    cycle(0, 1, '0, 0);
    repeat (10) cycle(0, 0, '0, 0);
    cycle(1, 0, '0, 0);
    repeat (70) cycle(0, 0, '0, 0);

    // Reset during CORE_RST.
    cycle(0, 0, '1, 1);
    cycle(1, 0, '1, 0);
    repeat (40) cycle(0, 0, '1, 0);
    check("in_core_rst", {29'b0, state_o}, 3);
    cycle(0, 0, '1, 1);
    check("mid_reset", {27'b0, state_o, io_link_reset_req_o}, {27'b0, 3'd0, 2'b11});

    // Randomized segments of steady or partially dead clocks.
    for (int s = 0; s < 60; s++) begin
      seg_a   = ($urandom % 4 == 0) ? N'($urandom) : '1;
      seg_len = $urandom_range(80, 5);
      for (int c = 0; c < seg_len; c++)
        cycle(($urandom % 16) == 0, ($urandom % 64) == 0, seg_a, ($urandom % 500) == 0);
    end

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
